// File: rtl/shaper_pkg.sv
// Shared types and sizes for the trapezoidal shaper datapath.
// Used by the peak sampler and its output holding register.
package shaper_pkg;

    localparam int SIZE_SHAPER_DATA     = 16;
    localparam int SIZE_SHAPER_CONSTANT = 8;
    localparam int SIZE_EVENT_COUNT     = 16;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        FLAT,
        FALL
    } peak_state_t;

    typedef struct packed {
        logic signed [SIZE_SHAPER_DATA-1:0] amplitude;
        logic                               pile_up;
    } peak_result_t;

endpackage

// File: rtl/shaper_result_reg.sv
// One-entry valid/ready holding register for finished peak results.
// full means a load this cycle would overwrite an unaccepted result.
module shaper_result_reg
    import shaper_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  peak_result_t load_data,
    input  logic         accept,
    output logic         valid,
    output peak_result_t data,
    output logic         full
);

    logic         valid_q, valid_d;
    peak_result_t data_q, data_d;

    always_comb begin
        valid_d = load | (valid_q & ~accept);
        data_d  = load ? load_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign full  = valid_q & ~accept;

endmodule

// File: rtl/trapez_peak_sampler.sv
// Detects trapezoid pulses over threshold, samples the flat-top centre and
// hands each result (amplitude + pile-up) to the histogram logic via valid/ready.
module trapez_peak_sampler
    import shaper_pkg::*;
#(
    parameter int SIZE_SHAPER_DATA     = shaper_pkg::SIZE_SHAPER_DATA,
    parameter int SIZE_SHAPER_CONSTANT = shaper_pkg::SIZE_SHAPER_CONSTANT,
    parameter int SIZE_EVENT_COUNT     = shaper_pkg::SIZE_EVENT_COUNT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               pulse_time,
    input  logic signed [SIZE_SHAPER_DATA-1:0] shaper_data,
    input  logic [SIZE_SHAPER_CONSTANT-1:0]    k_trapez,
    input  logic [SIZE_SHAPER_CONSTANT-1:0]    l_trapez,
    input  logic signed [SIZE_SHAPER_DATA-1:0] threshold,
    input  logic                               peak_ready,
    output logic signed [SIZE_SHAPER_DATA-1:0] peak_data,
    output logic                               peak_valid,
    output logic                               pile_up,
    output logic [SIZE_EVENT_COUNT-1:0]        event_count,
    output logic                               overrun
);

    // One extra bit so k+2 never wraps.
    localparam int CW = SIZE_SHAPER_CONSTANT + 1;

    peak_state_t                        state_q, state_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic signed [SIZE_SHAPER_DATA-1:0] sample_q, sample_d;
    logic                               ev_pile_q, ev_pile_d;
    logic                               pt_q;
    logic [SIZE_EVENT_COUNT-1:0]        event_count_q, event_count_d;
    logic                               overrun_q, overrun_d;

    logic          above, pt_rise, in_event;
    logic          capture, finish, timeout, load, full;
    logic [CW-1:0] k_eff, half_l, l_last;
    peak_result_t  result_in, result_out;

    assign above    = shaper_data > threshold;
    assign pt_rise  = pulse_time & ~pt_q;
    assign in_event = (state_q != IDLE);
    assign k_eff    = (k_trapez == '0) ? CW'(1) : {1'b0, k_trapez};
    assign half_l   = {2'b00, l_trapez[SIZE_SHAPER_CONSTANT-1:1]};
    assign l_last   = (l_trapez == '0) ? '0 : ({1'b0, l_trapez} - CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sample_q      <= '0;
            ev_pile_q     <= 1'b0;
            pt_q          <= 1'b0;
            event_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sample_q      <= sample_d;
            ev_pile_q     <= ev_pile_d;
            pt_q          <= pulse_time;
            event_count_q <= event_count_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enable && above) state_d = RISE;
            RISE: begin
                if (!enable || !above)        state_d = IDLE;
                else if (cnt_q == k_eff - 1'b1) state_d = FLAT;
            end
            FLAT: begin
                if (!enable)               state_d = IDLE;
                else if (cnt_q >= l_last)  state_d = FALL;
            end
            FALL: begin
                if (!enable || !above || cnt_q == k_eff + 2'd2) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        capture = (state_q == FLAT) && enable && (cnt_q == half_l);
        timeout = (state_q == FALL) && enable && above && (cnt_q == k_eff + 2'd2);
        finish  = (state_q == FALL) && enable && (!above || timeout);
        load    = finish && !full;

        sample_d = capture ? shaper_data : sample_q;

        ev_pile_d = ev_pile_q;
        if (state_q == IDLE && enable && above) ev_pile_d = 1'b0;
        else if (in_event && (pt_rise || timeout)) ev_pile_d = 1'b1;

        // An edge landing on the finish cycle still belongs to this event.
        result_in.amplitude = sample_q;
        result_in.pile_up   = ev_pile_q | (in_event & pt_rise) | timeout;

        event_count_d = event_count_q + SIZE_EVENT_COUNT'(load);
        overrun_d     = overrun_q | (finish & full);
    end

    shaper_result_reg u_result_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (result_in),
        .accept    (peak_ready),
        .valid     (peak_valid),
        .data      (result_out),
        .full      (full)
    );

    assign peak_data   = result_out.amplitude;
    assign pile_up     = result_out.pile_up;
    assign event_count = event_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_trapez_peak_sampler.sv
// Directed bench for trapez_peak_sampler: rectangular-ish pulses whose only
// full-amplitude sample sits exactly at the expected flat-top centre.
module tb_trapez_peak_sampler;

    logic               clk = 1'b0;
    logic               reset, enable, pulse_time, peak_ready;
    logic signed [15:0] shaper_data, threshold, peak_data;
    logic [7:0]         k_trapez, l_trapez;
    logic               peak_valid, pile_up, overrun;
    logic [15:0]        event_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    logic [15:0] acc_data;
    logic        acc_pile;
    int n0;

    always #5 clk = ~clk;

    trapez_peak_sampler dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pulse_time  (pulse_time),
        .shaper_data (shaper_data),
        .k_trapez    (k_trapez),
        .l_trapez    (l_trapez),
        .threshold   (threshold),
        .peak_ready  (peak_ready),
        .peak_data   (peak_data),
        .peak_valid  (peak_valid),
        .pile_up     (pile_up),
        .event_count (event_count),
        .overrun     (overrun)
    );

    // Records every handshake the consumer completes.
    always @(posedge clk) begin
        if (!reset && peak_valid && peak_ready) begin
            n_acc    = n_acc + 1;
            acc_data = peak_data;
            acc_pile = pile_up;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // j=0 crosses threshold; only j==cap carries the full amplitude.
    // abort_kind: 1 = reset pulse at j==abort_j, 2 = enable low at j==abort_j.
    task automatic pulse(input int amp, input int k, input int l, input int fall_hi,
                         input int pile_j, input int abort_j, input int abort_kind);
        int kf, lf, cap, last;
        kf   = (k == 0) ? 1 : k;
        lf   = (l == 0) ? 1 : l;
        cap  = kf + 1 + (l >> 1);
        last = kf + lf + fall_hi;
        k_trapez = 8'(k);
        l_trapez = 8'(l);
        for (int j = 0; j <= last; j++) begin
            shaper_data = (j == cap) ? 16'(amp) : 16'(amp / 2);
            pulse_time  = (j == pile_j);
            if (j == abort_j) begin
                if (abort_kind == 1) reset = 1'b1;
                else                 enable = 1'b0;
            end
            tick();
            reset  = 1'b0;
            enable = 1'b1;
            if (j == abort_j) break;
        end
        shaper_data = '0;
        pulse_time  = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pulse_time = 1'b0; peak_ready = 1'b1;
        shaper_data = '0; threshold = 16'sd100; k_trapez = 8'd4; l_trapez = 8'd6;
        repeat (2) tick();
        chk("rst_valid", {31'b0, peak_valid}, 0);
        chk("rst_data", {16'b0, peak_data}, 0);
        chk("rst_pile", {31'b0, pile_up}, 0);
        chk("rst_count", {16'b0, event_count}, 0);
        chk("rst_overrun", {31'b0, overrun}, 0);
        reset = 1'b0; enable = 1'b1;
        tick();

        // Clean pulse
        n0 = n_acc;
        pulse(1000, 4, 6, 2, -1, -1, 0);
        chk("clean_n", n_acc - n0, 1);
        chk("clean_data", {16'b0, acc_data}, 1000);
        chk("clean_pile", {31'b0, acc_pile}, 0);
        chk("clean_count", {16'b0, event_count}, 1);

        // Noise blip: two cycles above threshold
        n0 = n_acc;
        shaper_data = 16'sd200; repeat (2) tick();
        shaper_data = '0;       repeat (8) tick();
        chk("noise_n", n_acc - n0, 0);
        chk("noise_count", {16'b0, event_count}, 1);

        // pulse_time edge in FLAT
        pulse(800, 4, 6, 2, 7, -1, 0);
        chk("pt_data", {16'b0, acc_data}, 800);
        chk("pt_pile", {31'b0, acc_pile}, 1);
        chk("pt_count", {16'b0, event_count}, 2);

        // Fall lasting k+2 cycles above threshold: clean; k+3: timeout
        pulse(600, 4, 6, 6, -1, -1, 0);
        chk("fall_k2_pile", {31'b0, acc_pile}, 0);
        chk("fall_k2_data", {16'b0, acc_data}, 600);
        pulse(650, 4, 6, 7, -1, -1, 0);
        chk("fall_to_pile", {31'b0, acc_pile}, 1);
        chk("fall_to_data", {16'b0, acc_data}, 650);

        // Back-pressure across two pulses
        peak_ready = 1'b0;
        pulse(500, 4, 6, 2, -1, -1, 0);
        pulse(700, 4, 6, 2, -1, -1, 0);
        chk("bp_data", {16'b0, peak_data}, 500);
        chk("bp_valid", {31'b0, peak_valid}, 1);
        chk("bp_overrun", {31'b0, overrun}, 1);
        chk("bp_count", {16'b0, event_count}, 5);
        peak_ready = 1'b1;
        tick();
        chk("bp_drain", {31'b0, peak_valid}, 0);
        chk("bp_drain_data", {16'b0, acc_data}, 500);

        // Reset mid-FLAT
        n0 = n_acc;
        pulse(900, 4, 6, 2, -1, 7, 1);
        chk("rstmid_n", n_acc - n0, 0);
        chk("rstmid_valid", {31'b0, peak_valid}, 0);
        chk("rstmid_data", {16'b0, peak_data}, 0);
        chk("rstmid_count", {16'b0, event_count}, 0);
        chk("rstmid_overrun", {31'b0, overrun}, 0);
        chk("rstmid_pile", {31'b0, pile_up}, 0);
        pulse(300, 4, 6, 2, -1, -1, 0);
        chk("after_rst_data", {16'b0, acc_data}, 300);
        chk("after_rst_count", {16'b0, event_count}, 1);

        // enable low during RISE
        n0 = n_acc;
        pulse(400, 4, 6, 2, -1, 2, 2);
        chk("en_n", n_acc - n0, 0);
        chk("en_count", {16'b0, event_count}, 1);

        // k=0, l=0 edge constants
        threshold = 16'sd10;
        n0 = n_acc;
        pulse(50, 0, 0, 2, -1, -1, 0);
        chk("k0_n", n_acc - n0, 1);
        chk("k0_data", {16'b0, acc_data}, 50);
        chk("k0_pile", {31'b0, acc_pile}, 0);
        chk("k0_count", {16'b0, event_count}, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
